// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg -- shared CP0 definitions: register numbers, exception codes,
// Status/Cause bit positions, the Status write mask and small helpers.
package cp0_unit_pkg;

    // MFC0/MTC0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Exception codes; NONE and ERET are pipeline-internal encodings
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ERET = 5'h11;

    // Status / Cause bit positions
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_TI   = 30;

    // MTC0 may only touch IM[15:8], EXL and IE
    localparam logic [31:0] STATUS_WMASK = 32'h0000ff03;
    localparam logic [31:0] STATUS_RESET = 32'h10000000;
    localparam logic [31:0] PC_INIT      = 32'h00000000;

    typedef enum logic [1:0] {
        CMT_NONE = 2'd0,
        CMT_EXC  = 2'd1,
        CMT_ERET = 2'd2
    } commit_e;

    // Sort the committed code into no-op, exception or ERET
    function automatic commit_e classify_commit(input logic [4:0] code);
        commit_e kind;
        case (code)
            EXC_NONE: kind = CMT_NONE;
            EXC_ERET: kind = CMT_ERET;
            default:  kind = CMT_EXC;
        endcase
        return kind;
    endfunction

    // Assemble the architectural Cause view from its fields
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic       ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exccode);
        return {bd, ti, 14'd0, ip, 1'b0, exccode, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer -- Count/Compare timer with a power-of-two prescaler and the TI
// flag. Only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer
    import cp0_unit_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic        ti_clr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam logic [4:0] DIV_LAST = 5'(COUNT_DIV - 1);

    logic [4:0]  div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        tick_s;

    assign tick_s    = (div_q == DIV_LAST);
    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

    // Next-state for prescaler, Count, Compare and the timer-interrupt flag
    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = wdata_i;
            div_d   = 5'd0;
        end else if (tick_s) begin
            count_d = count_q + 32'd1;
            div_d   = 5'd0;
        end else begin
            div_d   = div_q + 5'd1;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
        end else begin
            compare_d = compare_q;
        end
        // TI rises as Count steps onto Compare; a Compare write always clears it
        if (ti_clr_i) begin
            ti_d = 1'b0;
        end else if (!count_we_i && tick_s && ((count_q + 32'd1) == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
    end

    // Timer state flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= 5'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

endmodule
`endif

// File: rtl/cp0_unit.sv
// cp0_unit -- CP0 register block: BadVAddr, Count, Compare, Status, Cause, EPC,
// exception/ERET commit, interrupt request and IF redirect.
// Optional feature macro: CP0_TIMER_EN (Count/Compare timer and TI).
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h00000100,
    parameter logic [31:0] INT_VECTOR = 32'h00000040
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [4:0]            raddr,
    output logic [31:0]           data_o,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic [4:0]            exccode_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delay_i,
    input  logic [31:0]           badvaddr_i,
    output logic                  int_req_o,
    output logic                  flush,
    output logic                  flush_im,
    output logic [31:0]           cp0_excaddr,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o
);

    if ((HW_INT_NUM < 1) || (HW_INT_NUM > 6) || (COUNT_DIV < 1) || (COUNT_DIV > 16) ||
        ((COUNT_DIV & (COUNT_DIV - 1)) != 0)) begin : g_bad_params
        $error("cp0_unit: HW_INT_NUM must be 1..6 and COUNT_DIV a power of two in 1..16");
    end

    logic [HW_INT_NUM-1:0] int_meta_q, int_meta_d, int_sync_q, int_sync_d;
    logic [31:0]           status_q, status_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;
    logic                  bd_q, bd_d;
    logic [4:0]            exccode_q, exccode_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic                  flush_im_q, flush_im_d;

    logic [31:0]           count_s, compare_s;
    logic                  ti_s;
    logic [5:0]            ip_hw_s;
    logic [7:0]            ip_s;
    logic [31:0]           cause_s;
    commit_e               commit_s;
    logic                  mtc0_s;

    // An exception commit swallows any MTC0 issued in the same cycle
    assign commit_s = classify_commit(exccode_i);
    assign mtc0_s   = we && (commit_s != CMT_EXC);

    // External lines fill IP[2..]; TI shares IP[7] with the sixth line
    assign ip_hw_s = 6'(int_sync_q);
    assign ip_s    = {ip_hw_s[5] | ti_s, ip_hw_s[4:0], ip_sw_q};
    assign cause_s = pack_cause(bd_q, ti_s, ip_s, exccode_q);

    assign status_o  = status_q;
    assign cause_o   = cause_s;
    assign flush_im  = flush_im_q;
    assign flush     = (commit_s != CMT_NONE);
    assign int_req_o = status_q[STATUS_IE] & ~status_q[STATUS_EXL] & (|(ip_s & status_q[15:8]));

`ifdef CP0_TIMER_EN
    logic count_we_s, compare_we_s;
    assign count_we_s   = mtc0_s && (waddr == CP0_COUNT);
    assign compare_we_s = mtc0_s && (waddr == CP0_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_cp0_timer (
        .clk          (cpu_clk_50M),
        .rst          (cpu_rst),
        .count_we_i   (count_we_s),
        .compare_we_i (compare_we_s),
        .ti_clr_i     (compare_we_s),
        .wdata_i      (wdata),
        .count_o      (count_s),
        .compare_o    (compare_s),
        .ti_o         (ti_s)
    );
`else
    assign count_s   = 32'd0;
    assign compare_s = 32'd0;
    assign ti_s      = 1'b0;
`endif

    // MFC0 read mux; returns the pre-write register contents
    always_comb begin
        data_o = 32'd0;
        if (re) begin
            case (raddr)
                CP0_BADVADDR: data_o = badvaddr_q;
                CP0_COUNT:    data_o = count_s;
                CP0_COMPARE:  data_o = compare_s;
                CP0_STATUS:   data_o = status_q;
                CP0_CAUSE:    data_o = cause_s;
                CP0_EPC:      data_o = epc_q;
                default:      data_o = 32'd0;
            endcase
        end else begin
            data_o = 32'd0;
        end
    end

    // Redirect target; ERET sees a same-cycle MTC0 to EPC
    always_comb begin
        cp0_excaddr = PC_INIT;
        case (commit_s)
            CMT_NONE: cp0_excaddr = PC_INIT;
            CMT_ERET: begin
                if (we && (waddr == CP0_EPC)) begin
                    cp0_excaddr = wdata;
                end else begin
                    cp0_excaddr = epc_q;
                end
            end
            CMT_EXC: begin
                if (exccode_i == EXC_INT) begin
                    cp0_excaddr = INT_VECTOR;
                end else begin
                    cp0_excaddr = EXC_VECTOR;
                end
            end
            default:  cp0_excaddr = PC_INIT;
        endcase
    end

    // Register next-state: MTC0 first, then exception/ERET commit on top
    always_comb begin
        int_meta_d = int_i;
        int_sync_d = int_meta_q;
        flush_im_d = flush;
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        if (mtc0_s) begin
            case (waddr)
                CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
                CP0_CAUSE:  ip_sw_d  = wdata[9:8];
                CP0_EPC:    epc_d    = wdata;
                default:    ip_sw_d  = ip_sw_q;
            endcase
        end else begin
            ip_sw_d = ip_sw_q;
        end
        if (commit_s == CMT_EXC) begin
            // A nested exception keeps the original return point
            if (!status_q[STATUS_EXL]) begin
                if (in_delay_i) begin
                    epc_d = pc_i - 32'd4;
                    bd_d  = 1'b1;
                end else begin
                    epc_d = pc_i;
                    bd_d  = 1'b0;
                end
            end else begin
                epc_d = epc_q;
                bd_d  = bd_q;
            end
            status_d[STATUS_EXL] = 1'b1;
            exccode_d            = exccode_i;
            if ((exccode_i == EXC_ADEL) || (exccode_i == EXC_ADES)) begin
                badvaddr_d = badvaddr_i;
            end else begin
                badvaddr_d = badvaddr_q;
            end
        end else if (commit_s == CMT_ERET) begin
            status_d[STATUS_EXL] = 1'b0;
        end else begin
            exccode_d = exccode_q;
        end
    end

    // Synchroniser and delayed flush flops
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            int_meta_q <= '0;
            int_sync_q <= '0;
            flush_im_q <= 1'b0;
        end else begin
            int_meta_q <= int_meta_d;
            int_sync_q <= int_sync_d;
            flush_im_q <= flush_im_d;
        end
    end

    // Architectural CP0 register flops
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            status_q   <= STATUS_RESET;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            ip_sw_q    <= 2'd0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit -- self-checking bench for cp0_unit (default parameters).
// Timer scenarios are included when CP0_TIMER_EN is defined.
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, re, in_delay_i;
    logic [4:0]  waddr, raddr, exccode_i;
    logic [31:0] wdata, data_o, pc_i, badvaddr_i;
    logic [5:0]  int_i;
    logic        int_req_o, flush, flush_im;
    logic [31:0] cp0_excaddr, status_o, cause_o;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v, obs;

    always #5 clk = ~clk;

    cp0_unit dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re          (re),
        .raddr       (raddr),
        .data_o      (data_o),
        .int_i       (int_i),
        .exccode_i   (exccode_i),
        .pc_i        (pc_i),
        .in_delay_i  (in_delay_i),
        .badvaddr_i  (badvaddr_i),
        .int_req_o   (int_req_o),
        .flush       (flush),
        .flush_im    (flush_im),
        .cp0_excaddr (cp0_excaddr),
        .status_o    (status_o),
        .cause_o     (cause_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; exccode_i = EXC_NONE; in_delay_i = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
        re = 1'b1; raddr = a;
        #1;
        d = data_o;
        re = 1'b0;
    endtask

    task automatic test_reset();
        exp_q.push_back(32'h10000000); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h10000000);
        exp_v = exp_q.pop_front(); n_cmp++; if (status_o !== exp_v) begin n_mis++; $display("FAIL rst_status: got %h want %h", status_o, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL rst_cause: got %h want %h", cause_o, exp_v); end
        obs = {29'd0, int_req_o, flush, flush_im};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL rst_flags: got %h want %h", obs, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (cp0_excaddr !== exp_v) begin n_mis++; $display("FAIL rst_excaddr: got %h want %h", cp0_excaddr, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (data_o !== exp_v) begin n_mis++; $display("FAIL rst_data_o: got %h want %h", data_o, exp_v); end
        mfc0(CP0_STATUS, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL rst_mfc0_status: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_interrupt();
        mtc0(CP0_STATUS, 32'h00000401);
        exp_q.push_back(32'h10000401);
        exp_v = exp_q.pop_front(); n_cmp++; if (status_o !== exp_v) begin n_mis++; $display("FAIL int_status_wr: got %h want %h", status_o, exp_v); end
        int_i = 6'b000001;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        cyc();
        obs = {31'd0, cause_o[10]};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL int_ip2_1cyc: got %h want %h", obs, exp_v); end
        cyc();
        obs = {31'd0, cause_o[10]};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL int_ip2_2cyc: got %h want %h", obs, exp_v); end
        obs = {31'd0, int_req_o};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL int_req_on: got %h want %h", obs, exp_v); end
        mtc0(CP0_STATUS, 32'h00000403);
        obs = {31'd0, int_req_o};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL int_req_exl: got %h want %h", obs, exp_v); end
        int_i = 6'b000000;
        mtc0(CP0_STATUS, 32'h00000000);
        cyc(); cyc();
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL int_cleared: got %h want %h", cause_o, exp_v); end
    endtask

    task automatic test_sw_int();
        exp_q.push_back(32'h00000300); exp_q.push_back(32'd1); exp_q.push_back(32'h0);
        mtc0(CP0_CAUSE, 32'hffffffff);
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL sw_cause_mask: got %h want %h", cause_o, exp_v); end
        mtc0(CP0_STATUS, 32'h00000101);
        obs = {31'd0, int_req_o};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL sw_int_req: got %h want %h", obs, exp_v); end
        mtc0(CP0_CAUSE, 32'h00000000);
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL sw_cause_clr: got %h want %h", cause_o, exp_v); end
        mtc0(CP0_STATUS, 32'h00000000);
    endtask

    task automatic test_delay_exc();
        exccode_i = EXC_ADEL; pc_i = 32'h100; in_delay_i = 1'b1; badvaddr_i = 32'h13;
        exp_q.push_back(32'd1); exp_q.push_back(32'h100); exp_q.push_back(32'd0);
        #1;
        obs = {31'd0, flush};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL dexc_flush: got %h want %h", obs, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (cp0_excaddr !== exp_v) begin n_mis++; $display("FAIL dexc_excaddr: got %h want %h", cp0_excaddr, exp_v); end
        obs = {31'd0, flush_im};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL dexc_flush_im_early: got %h want %h", obs, exp_v); end
        exp_q.push_back(32'd1); exp_q.push_back(32'h000000fc); exp_q.push_back(32'h13);
        exp_q.push_back(32'h80000010); exp_q.push_back(32'h10000002);
        cyc(); idle();
        obs = {31'd0, flush_im};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL dexc_flush_im: got %h want %h", obs, exp_v); end
        mfc0(CP0_EPC, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL dexc_epc: got %h want %h", obs, exp_v); end
        mfc0(CP0_BADVADDR, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL dexc_badvaddr: got %h want %h", obs, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL dexc_cause: got %h want %h", cause_o, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (status_o !== exp_v) begin n_mis++; $display("FAIL dexc_status: got %h want %h", status_o, exp_v); end
    endtask

    task automatic test_nested_exc();
        exccode_i = EXC_ADES; pc_i = 32'h200; in_delay_i = 1'b0; badvaddr_i = 32'h77;
        exp_q.push_back(32'h000000fc); exp_q.push_back(32'h80000014); exp_q.push_back(32'h77);
        cyc(); idle();
        mfc0(CP0_EPC, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL nest_epc: got %h want %h", obs, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL nest_cause: got %h want %h", cause_o, exp_v); end
        mfc0(CP0_BADVADDR, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL nest_badvaddr: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_eret_bypass();
        exccode_i = EXC_ERET; we = 1'b1; waddr = CP0_EPC; wdata = 32'h2000;
        exp_q.push_back(32'h2000); exp_q.push_back(32'h10000000); exp_q.push_back(32'h2000); exp_q.push_back(32'h3000);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++; if (cp0_excaddr !== exp_v) begin n_mis++; $display("FAIL eret_bypass_addr: got %h want %h", cp0_excaddr, exp_v); end
        cyc(); idle();
        exp_v = exp_q.pop_front(); n_cmp++; if (status_o !== exp_v) begin n_mis++; $display("FAIL eret_exl_clr: got %h want %h", status_o, exp_v); end
        mfc0(CP0_EPC, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL eret_epc_wr: got %h want %h", obs, exp_v); end
        mtc0(CP0_EPC, 32'h3000);
        exccode_i = EXC_ERET;
        #1;
        exp_v = exp_q.pop_front(); n_cmp++; if (cp0_excaddr !== exp_v) begin n_mis++; $display("FAIL eret_epc_addr: got %h want %h", cp0_excaddr, exp_v); end
        cyc(); idle();
    endtask

    task automatic test_exc_mtc0_discard();
        exccode_i = EXC_SYS; pc_i = 32'h300; in_delay_i = 1'b0;
        we = 1'b1; waddr = CP0_STATUS; wdata = 32'h0000ff01;
        exp_q.push_back(32'h10000002); exp_q.push_back(32'h00000020); exp_q.push_back(32'h300);
        exp_q.push_back(32'h40); exp_q.push_back(32'h0); exp_q.push_back(32'h10000000);
        cyc(); idle();
        exp_v = exp_q.pop_front(); n_cmp++; if (status_o !== exp_v) begin n_mis++; $display("FAIL disc_status: got %h want %h", status_o, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL disc_cause: got %h want %h", cause_o, exp_v); end
        mfc0(CP0_EPC, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL disc_epc: got %h want %h", obs, exp_v); end
        exccode_i = EXC_INT;
        #1;
        exp_v = exp_q.pop_front(); n_cmp++; if (cp0_excaddr !== exp_v) begin n_mis++; $display("FAIL int_vector: got %h want %h", cp0_excaddr, exp_v); end
        cyc(); idle();
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL int_exccode: got %h want %h", cause_o, exp_v); end
        exccode_i = EXC_ERET;
        cyc(); idle();
        exp_v = exp_q.pop_front(); n_cmp++; if (status_o !== exp_v) begin n_mis++; $display("FAIL disc_eret: got %h want %h", status_o, exp_v); end
    endtask

    task automatic test_read();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h300); exp_q.push_back(32'h4444);
        re = 1'b0; raddr = CP0_STATUS;
        #1;
        exp_v = exp_q.pop_front(); n_cmp++; if (data_o !== exp_v) begin n_mis++; $display("FAIL rd_re_low: got %h want %h", data_o, exp_v); end
        mfc0(5'd10, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL rd_unmapped: got %h want %h", obs, exp_v); end
        we = 1'b1; waddr = CP0_EPC; wdata = 32'h4444;
        mfc0(CP0_EPC, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL rd_prewrite: got %h want %h", obs, exp_v); end
        cyc(); we = 1'b0;
        mfc0(CP0_EPC, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL rd_postwrite: got %h want %h", obs, exp_v); end
`ifndef CP0_TIMER_EN
        mtc0(CP0_COUNT, 32'h55);
        mtc0(CP0_COMPARE, 32'h66);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        mfc0(CP0_COUNT, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL rd_count_off: got %h want %h", obs, exp_v); end
        mfc0(CP0_COMPARE, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL rd_compare_off: got %h want %h", obs, exp_v); end
`endif
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        int cycles;
        logic seen;
        mtc0(CP0_COMPARE, 32'd3);
        mtc0(CP0_COUNT, 32'd0);
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd1);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 20) begin
            cyc();
            cycles++;
            seen = cause_o[CAUSE_TI];
        end
        obs = {31'd0, seen};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL tmr_ti_set: got %h want %h", obs, exp_v); end
        obs = {31'd0, (cycles >= 5) && (cycles <= 8)};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL tmr_latency: got %0d cycles want 5..8", cycles); end
        mfc0(CP0_COUNT, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL tmr_count: got %h want %h", obs, exp_v); end
        obs = {31'd0, cause_o[15]};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL tmr_ip7: got %h want %h", obs, exp_v); end
        mtc0(CP0_STATUS, 32'h00008001);
        obs = {31'd0, int_req_o};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL tmr_int_req: got %h want %h", obs, exp_v); end
        mtc0(CP0_COMPARE, 32'd10);
        obs = {31'd0, cause_o[CAUSE_TI]};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL tmr_ti_clr: got %h want %h", obs, exp_v); end
        obs = {31'd0, int_req_o};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL tmr_int_req_clr: got %h want %h", obs, exp_v); end
        mtc0(CP0_STATUS, 32'h00000000);
    endtask
`endif

    task automatic test_reset_midrun();
`ifdef CP0_TIMER_EN
        mtc0(CP0_COUNT, 32'd5);
`endif
        exccode_i = EXC_ADEL; pc_i = 32'h500; badvaddr_i = 32'h99; in_delay_i = 1'b0;
        cyc(); idle();
        exp_q.push_back(32'd1); exp_q.push_back(32'h10000000); exp_q.push_back(32'h0);
        exp_q.push_back(32'd0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        obs = {31'd0, flush_im};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL mid_pre_flush_im: got %h want %h", obs, exp_v); end
        #2 rst = 1'b1;
        #1;
        exp_v = exp_q.pop_front(); n_cmp++; if (status_o !== exp_v) begin n_mis++; $display("FAIL mid_status: got %h want %h", status_o, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++; if (cause_o !== exp_v) begin n_mis++; $display("FAIL mid_cause: got %h want %h", cause_o, exp_v); end
        obs = {31'd0, flush_im};
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL mid_flush_im: got %h want %h", obs, exp_v); end
        mfc0(CP0_EPC, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL mid_epc: got %h want %h", obs, exp_v); end
        mfc0(CP0_BADVADDR, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL mid_badvaddr: got %h want %h", obs, exp_v); end
`ifdef CP0_TIMER_EN
        exp_q.push_back(32'h0);
        mfc0(CP0_COUNT, obs);
        exp_v = exp_q.pop_front(); n_cmp++; if (obs !== exp_v) begin n_mis++; $display("FAIL mid_count: got %h want %h", obs, exp_v); end
`endif
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; idle();
        waddr = 5'd0; wdata = 32'd0; raddr = 5'd0;
        int_i = 6'd0; pc_i = 32'd0; badvaddr_i = 32'd0;
        cyc(); cyc();
        rst = 1'b0;
        test_reset();
        test_interrupt();
        test_sw_int();
        test_delay_exc();
        test_nested_exc();
        test_eret_bypass();
        test_exc_mtc0_discard();
        test_read();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Parametrised successor of the CP0 register block. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and commits exceptions and ERET. It synchronises HW_INT_NUM external interrupt lines, adds software interrupts and a Count/Compare timer, and raises a masked interrupt request to the MEM stage. It sits beside the MEM/WB boundary and feeds flush and redirect to IF.

Parameters:
HW_INT_NUM, 6, number of external interrupt lines; 1..5 map to Cause.IP[2+HW_INT_NUM-1:2]; at 6, IP[7] is int_i[5] OR TI.
COUNT_DIV, 2, core cycles per Count increment; power of two, 1..16.
EXC_VECTOR, 32'h00000100, redirect target for non-interrupt exceptions.
INT_VECTOR, 32'h00000040, redirect target for EXC_INT.

Ports:
cpu_clk_50M  in  1  core clock.
cpu_rst  in  1  reset; asynchronous, active-high.
we  in  1  MTC0 write enable.
waddr  in  5  MTC0 register number.
wdata  in  32  MTC0 data.
re  in  1  MFC0 read enable.
raddr  in  5  MFC0 register number.
data_o  out  32  MFC0 read data; combinational.
int_i  in  HW_INT_NUM  asynchronous external interrupt lines.
exccode_i  in  5  committed exception code; EXC_NONE when no exception.
pc_i  in  32  PC of the committing instruction.
in_delay_i  in  1  committing instruction is in a delay slot.
badvaddr_i  in  32  faulting address for ADEL/ADES.
int_req_o  out  1  pending enabled interrupt; MEM converts it to EXC_INT.
flush  out  1  combinational pipeline flush.
flush_im  out  1  flush delayed one cycle, for the IM read.
cp0_excaddr  out  32  redirect PC.
status_o, cause_o  out  32  raw register views for forwarding.

Behaviour:
- Reset (async, cpu_rst=1): BadVAddr=0, Count=0, Compare=0, Status=32'h10000000, Cause=0, EPC=0, divider=0, TI=0, sync flops=0, flush_im=0.
- Reset outputs: int_req_o=0, flush=0, cp0_excaddr=32'h00000000 (PC_INIT), data_o=0.
- int_i: two-flop synchroniser. Synchronised value enters Cause.IP[2+HW_INT_NUM-1:2] every cycle, so latency is 2 cycles from an edge to visibility in Cause. Unused IP bits read 0.
- Cause.IP[1:0] (software interrupts) are writable by MTC0. Other Cause bits are read-only to MTC0.
- Status MTC0 write mask: IM[15:8], EXL[1], IE[0]; other bits hold.
- int_req_o = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]); combinational from registered state.
- Count: divider counts 0..COUNT_DIV-1; Count increments by 1 on the wrap cycle and wraps 2^32-1 -> 0.
- Timer: TI (Cause[30]) sets in the cycle after Count==Compare while Count increments. TI clears on any MTC0 to Compare.
- MTC0 to Count: overrides the increment in that cycle and resets the divider.
- Exception (exccode_i not EXC_NONE or EXC_ERET):
  - If EXL=0: EPC=pc_i-4 and BD(Cause[31])=1 when in_delay_i, else EPC=pc_i and BD=0.
  - EXL<=1; Cause.ExcCode[6:2]<=exccode_i.
  - ADEL/ADES also load BadVAddr<=badvaddr_i.
  - Any MTC0 in the same cycle is discarded.
- ERET: EXL<=0. cp0_excaddr=EPC, or wdata when a same-cycle MTC0 targets EPC (bypass).
- flush=1 iff exccode_i!=EXC_NONE.
- cp0_excaddr: INT_VECTOR for EXC_INT; EXC_VECTOR for other exceptions; 0 when no exception.
- flush_im <= flush every cycle.
- MFC0: addresses 8, 9, 11, 12, 13, 14 return the register; other addresses and re=0 return 0. Data is pre-write, with no internal bypass.

Optional Feature:
CP0_TIMER_EN.
- Defined: Count/Compare/TI logic as above.
- Undefined: no divider or Count/Compare storage; registers 9 and 11 read 0 and ignore writes; TI is constant 0; IP[7] is int_i[5] only.

Decomposition:
- Shared defines package: CP0 register numbers (BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14), EXC_* codes, Status/Cause bit positions, Status write mask, PC_INIT.
- One sub-module: cp0_timer (divider, Count, Compare, TI; inputs for write and clear strobes). Instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset mid-run: assert cpu_rst asynchronously with Count=5 -> all registers at reset values immediately; Status reads 32'h10000000.
- Interrupt: int_i[0]=1, Status=32'h00000401 -> Cause.IP[2]=1 after 2 cycles, int_req_o=1; with Status.EXL=1, int_req_o=0.
- Timer (COUNT_DIV=2):
  - Compare=3, Count=0 -> TI=1 after Count reaches 3 (about 6-7 cycles); with IM[7]=1, IE=1, int_req_o=1.
  - MTC0 Compare=10 -> TI=0 next cycle.
- Delay-slot exception: exccode_i=ADEL, pc_i=32'h100, in_delay_i=1, badvaddr_i=32'h13 -> EPC=32'hFC, BD=1, BadVAddr=32'h13, flush=1, cp0_excaddr=32'h100, flush_im=1 next cycle.
- Nested exception: second exception with EXL=1 -> EPC unchanged, ExcCode updated.
- ERET with same-cycle MTC0 EPC=32'h2000 -> cp0_excaddr=32'h2000, EXL=0.
- Same-cycle exception and MTC0 Status -> MTC0 discarded.
